// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed LSB-first serial transmitter with start/busy handshake.
// Optional even parity bit between data and stop when SER_TX_PARITY_EN is defined.
module serial_frame_tx #(
  parameter int DATA_W = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] dataIn,
  output logic              serOut,
  output logic              busy,
  output logic              shEn,
  output logic              Done
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3;
`ifdef SER_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif
  localparam logic [7:0] CMAX = 8'(BIT_CYCLES - 1);
  localparam logic [5:0] LAST = 6'(DATA_W - 1);
  logic [2:0] state, nState;
  logic [7:0] cnt, nCnt;
  logic [5:0] idx, nIdx;
  logic [DATA_W-1:0] shift, nShift;
  logic endBit;
`ifdef SER_TX_PARITY_EN
  logic par, nPar;
`endif
  always_comb begin
    endBit = cnt == CMAX;
    nState = state;
    nCnt = endBit ? 8'd0 : cnt + 8'd1;
    nIdx = idx;
    nShift = shift;
    case (state)
      IDLE: begin
        nCnt = 8'd0;
        if (start) begin
          nState = START;
          nShift = dataIn;
          nIdx = 6'd0;
        end
      end
      START: nState = endBit ? DATA : state;
      DATA: if (endBit) begin
        nShift = shift >> 1;
        nIdx = idx + 6'd1;
`ifdef SER_TX_PARITY_EN
        nState = idx == LAST ? PARITY : state;
`else
        nState = idx == LAST ? STOP : state;
`endif
      end
`ifdef SER_TX_PARITY_EN
      PARITY: nState = endBit ? STOP : state;
`endif
      default: nState = endBit ? IDLE : state;
    endcase
  end
`ifdef SER_TX_PARITY_EN
  // Parity is taken from the word at capture so it survives the shifting.
  assign nPar = (state == IDLE && start) ? ^dataIn : par;
`endif
  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      serOut <= 1'b1;
      busy <= 1'b0;
      shEn <= 1'b0;
      Done <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= nState;
      cnt <= nCnt;
      idx <= nIdx;
      shift <= nShift;
      busy <= nState != IDLE;
      shEn <= nState == DATA;
      Done <= state == STOP && endBit;
`ifdef SER_TX_PARITY_EN
      par <= nPar;
      serOut <= nState == START ? 1'b0 : nState == DATA ? nShift[0] : nState == PARITY ? nPar : 1'b1;
`else
      serOut <= nState == START ? 1'b0 : nState == DATA ? nShift[0] : 1'b1;
`endif
    end
  end
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: accepts a parallel word through a start/busy handshake and drives it onto a single-wire serial line as a framed bit stream, LSB first. It is the transmit end of the same single-wire serial link whose receive-side controller consumes `serIn` and reports `shEn`/`Done`. Outputs are all registered. The block sits between the parallel data source and the serial line.

## Interface
- `DATA_W`, 8: data bits per frame; legal range 1..32.
- `BIT_CYCLES`, 1: CLK cycles each bit is held on `serOut`; legal range 1..255.

- `CLK`  input  1  single clock; all state changes on the rising edge.
- `RST`  input  1  reset, synchronous and active-high.
- `start`  input  1  request to send; sampled only while `busy`=0.
- `dataIn`  input  DATA_W  word to send; captured on the edge where `start` is accepted.
- `serOut`  output  1  serial line; idles high.
- `busy`  output  1  high from the cycle after acceptance through the last stop-bit cycle.
- `shEn`  output  1  high exactly while data bits are being driven.
- `Done`  output  1  one-cycle pulse after the frame completes.

## Operation
- States:
  - IDLE: `serOut`=1, `busy`=0, `shEn`=0.
  - START: `serOut`=0.
  - DATA: `serOut` = current shift-register LSB, `shEn`=1.
  - PARITY: present only with the macro defined.
  - STOP: `serOut`=1.
- IDLE to START: on a rising edge with `start`=1, `dataIn` is copied into the shift register, the bit index is cleared, and the cycle counter is cleared.
- Every state except IDLE lasts exactly BIT_CYCLES cycles. A cycle counter runs 0..BIT_CYCLES-1 and wraps to 0 when the state advances.
- DATA: at the end of each bit period the register shifts right by one and the bit index increments. After the last bit (index DATA_W-1) the state goes to PARITY, or to STOP without the macro.
- STOP to IDLE: at the end of the stop period. `Done`=1 during the first IDLE cycle.
- `start` while `busy`=1 is ignored, and `dataIn` changes are ignored after capture.
- Back-to-back frames: `start`=1 in the `Done` cycle is accepted. The next START begins the following cycle with no extra idle bit.
- Reset, including mid-frame: the state returns to IDLE on the next edge and the frame is abandoned.
  - After reset: `serOut`=1, `busy`=0, `shEn`=0, `Done`=0.
  - The shift register, counters and bit index clear to 0.
  - No `Done` pulse is generated for an aborted frame.
  - `RST` has priority over `start` in the same cycle.

## Timing
- Acceptance latency: 1 cycle. `serOut` falls and `busy` rises on the edge that samples `start`=1.
- Frame length in cycles: BIT_CYCLES·(DATA_W+2), or BIT_CYCLES·(DATA_W+3) with parity. `busy` is high for exactly that many cycles.
- Data bit k (k=0..DATA_W-1) is on `serOut` during cycles BIT_CYCLES·(1+k) through BIT_CYCLES·(2+k)-1, counted from the first START cycle.
- `shEn` is high for BIT_CYCLES·DATA_W consecutive cycles.
- `Done` rises the cycle after the last stop-bit cycle and is high for 1 cycle. `busy` is 0 in that cycle.
- Minimum accept-to-accept spacing: frame length + 1 cycles.

## Configuration
- `SER_TX_PARITY_EN` defined:
  - A PARITY state lasting BIT_CYCLES is inserted between DATA and STOP.
  - `serOut` in PARITY is the XOR of all captured data bits (even parity).
  - `shEn`=0 during PARITY.
- `SER_TX_PARITY_EN` undefined: DATA goes directly to STOP, and no parity logic is present.

## Test plan
- Reset hold: `RST`=1 for 3 cycles with `start`=1 → `serOut`=1, `busy`=0, `shEn`=0, `Done`=0 throughout. No frame starts.
- Basic frame (DATA_W=8, BIT_CYCLES=1, no parity), `dataIn`=8'hA5:
  - `serOut` = 0,1,0,1,0,0,1,0,1,1 on consecutive cycles.
  - `busy` high for 10 cycles.
  - `shEn` high on cycles 2–9.
  - `Done` pulses on cycle 11.
- Stretched bits (BIT_CYCLES=3), `dataIn`=8'h01: `serOut` = 0×3, 1×3, 0×21, 1×3. `busy` high for 30 cycles, then `Done` for 1 cycle.
- Parity (`SER_TX_PARITY_EN`, BIT_CYCLES=1):
  - `dataIn`=8'h07 → parity bit 1; frame is 0,1,1,1,0,0,0,0,0,1,1 (11 busy cycles).
  - `dataIn`=8'hA5 → parity bit 0.
- Handshake:
  - `start` pulsed mid-frame with a different `dataIn` → ignored; the transmitted word is unchanged.
  - `start`=1 in the `Done` cycle with `dataIn`=8'h3C → the next START begins on the following cycle and 8'h3C is sent.
- Mid-frame reset: `RST`=1 during data bit 4 → next cycle `serOut`=1, `busy`=0, `shEn`=0, and no `Done` pulse. A new `start` afterwards sends a complete, correct frame.
